// File: rtl/edge_detect_stream.sv
// rtl/edge_detect_stream.sv - streaming 3x3 Sobel/Prewitt edge detector with line buffers
`timescale 1ns/1ps
module edge_detect_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 64,
  parameter int unsigned EDGE_VAL   = 0,
  parameter int unsigned BG_VAL     = 2**DATA_WIDTH-1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_sof_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH+3:0] threshold_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_sof_o,
  output logic                  out_eol_o,
  output logic                  frame_done_o,
  output logic                  sof_err_o
);
  localparam int unsigned SW = DATA_WIDTH + 4;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [SW-1:0] PIX_MAX  = SW'(2**DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] EDGE_PIX = DATA_WIDTH'(EDGE_VAL);
  localparam logic [DATA_WIDTH-1:0] BG_PIX   = DATA_WIDTH'(BG_VAL);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [1:0]    mode_q;
  logic [SW-1:0] thr_q;
  logic          sof_err_q, out_valid_q, out_sof_q, out_eol_q, out_last_q, frame_done_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic          accept;

  // line buffers hold rows r-2 (top) and r-1 (mid); window keeps columns c-2 (a) and c-1 (b)
  logic [DATA_WIDTH-1:0] lb_top [IMG_W];
  logic [DATA_WIDTH-1:0] lb_mid [IMG_W];
  logic [2:0][DATA_WIDTH-1:0] wa_q, wb_q, new_col;
  logic [DATA_WIDTH-1:0] px [3][3];

  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0] ax, ay, mag_sum, mag;
  logic          prewitt;
  logic [DATA_WIDTH-1:0] result;

  function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  function automatic logic signed [SW-1:0] wgt(input logic pw, input logic [DATA_WIDTH-1:0] v);
    return pw ? ext(v) : (ext(v) <<< 1);
  endfunction

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign cur_col    = in_sof_i ? '0 : col_q;
  assign cur_row    = in_sof_i ? '0 : row_q;

  always_comb begin
    col_d = cur_col + CW'(1);
    row_d = cur_row;
    if (cur_col == COL_LAST) begin
      col_d = '0;
      row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    end
  end

  always_comb begin
    new_col = {in_data_i, lb_mid[cur_col], lb_top[cur_col]};
    for (int r = 0; r < 3; r++) begin
      px[r][0] = wa_q[r];
      px[r][1] = wb_q[r];
      px[r][2] = new_col[r];
    end
  end

  always_comb begin
    prewitt = (mode_q == 2'b01);
    gx = (ext(px[0][2]) + wgt(prewitt, px[1][2]) + ext(px[2][2]))
       - (ext(px[0][0]) + wgt(prewitt, px[1][0]) + ext(px[2][0]));
    gy = (ext(px[2][0]) + wgt(prewitt, px[2][1]) + ext(px[2][2]))
       - (ext(px[0][0]) + wgt(prewitt, px[0][1]) + ext(px[0][2]));
    ax      = gx[SW-1] ? -gx : gx;
    ay      = gy[SW-1] ? -gy : gy;
    mag_sum = ax + ay;
    mag     = (mode_q == 2'b10) ? ((ax > ay) ? ax : ay) : mag_sum;
    if (mode_q == 2'b11) begin
      result = (mag_sum > PIX_MAX) ? PIX_MAX[DATA_WIDTH-1:0] : mag_sum[DATA_WIDTH-1:0];
    end else begin
      result = (mag > thr_q) ? EDGE_PIX : BG_PIX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb_top[cur_col] <= lb_mid[cur_col];
      lb_mid[cur_col] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 2'b00;
      thr_q        <= '0;
      sof_err_q    <= 1'b0;
      wa_q         <= '0;
      wb_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_valid_q && out_ready_i && out_last_q;
      if (out_ready_i) out_valid_q <= 1'b0;
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        wa_q  <= wb_q;
        wb_q  <= new_col;
        if (in_sof_i) begin
          mode_q <= mode_i;
          thr_q  <= threshold_i;
          if (col_q != '0 || row_q != '0) sof_err_q <= 1'b1;
        end
        if (cur_row >= ROW_TWO && cur_col >= COL_TWO) begin
          out_valid_q <= 1'b1;
          out_data_q  <= result;
          out_sof_q   <= (cur_row == ROW_TWO) && (cur_col == COL_TWO);
          out_eol_q   <= (cur_col == COL_LAST);
          out_last_q  <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_sof_o    = out_sof_q;
  assign out_eol_o    = out_eol_q;
  assign frame_done_o = frame_done_q;
  assign sof_err_o    = sof_err_q;
endmodule

// File: tb/tb_edge_detect_stream.sv
// tb/tb_edge_detect_stream.sv - scoreboard bench for edge_detect_stream on 5x5 frames
`timescale 1ns/1ps
module tb_edge_detect_stream;
  localparam logic [39:0] ALL100 = {5{8'd100}};
  localparam logic [39:0] STEP   = {8'd100, 8'd100, 8'd0, 8'd0, 8'd0};

  logic        clk_i = 1'b0;
  logic        rst_ni, in_valid_i, in_ready_o, in_sof_i;
  logic        out_valid_o, out_ready_i, out_sof_o, out_eol_o, frame_done_o, sof_err_o;
  logic [7:0]  in_data_i, out_data_o;
  logic [1:0]  mode_i;
  logic [11:0] threshold_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [9:0]  sb [$];
  logic [9:0]  exp_px;
  logic [10:0] snap;
  int          kwait;

  edge_detect_stream #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_sof_i(in_sof_i),
    .mode_i(mode_i), .threshold_i(threshold_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_sof_o(out_sof_o), .out_eol_o(out_eol_o),
    .frame_done_o(frame_done_o), .sof_err_o(sof_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic s);
    int   n;
    logic ok;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_sof_i   = s;
    n = 0;
    do begin
      @(negedge clk_i);
      ok = in_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_pixel_timeout: in_ready_o stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  // line holds the hand-computed value for output columns 0..2 in bytes 0..2
  task automatic send_frame(input logic [39:0] cols, input logic sof0, input int gap,
                            input int npix, input logic chg, input logic [23:0] line,
                            input logic push);
    if (push) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          sb.push_back({line[c*8 +: 8], (r == 0 && c == 0), (c == 2)});
    end
    for (int p = 0; p < npix; p++) begin
      send_pixel(cols[(p % 5)*8 +: 8], sof0 && (p == 0));
      if (chg && p == 10) begin
        mode_i      = 2'b11;
        threshold_i = 12'd0;
      end
      if (gap > 0) begin
        in_valid_i = 1'b0;
        repeat (gap) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    in_valid_i = 1'b0;
    in_sof_i   = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (frame_done_o) n_done++;
        if (out_valid_o && out_ready_i) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: got data=%0d sof=%b eol=%b, required no output",
                     out_data_o, out_sof_o, out_eol_o);
          end else begin
            exp_px = sb.pop_front();
            check("out_pixel", 32'({out_data_o, out_sof_o, out_eol_o}), 32'(exp_px));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_sof_i = 1'b0;
    mode_i = 2'b00; threshold_i = '0; out_ready_i = 1'b1;
    #2;
    check("reset_outputs", 32'({out_valid_o, out_data_o, out_sof_o, out_eol_o, frame_done_o, sof_err_o}), 32'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", 32'(in_ready_o), 32'(1));
    @(posedge clk_i);
    #1;

    mode_i = 2'b00; threshold_i = 12'd50;
    send_frame(ALL100, 1'b1, 0, 25, 1'b0, {8'd255, 8'd255, 8'd255}, 1'b1);
    send_frame(STEP, 1'b1, 0, 25, 1'b1, {8'd0, 8'd0, 8'd255}, 1'b1);
    mode_i = 2'b11; threshold_i = 12'd0;
    send_frame(STEP, 1'b1, 1, 25, 1'b0, {8'd255, 8'd255, 8'd0}, 1'b1);
    mode_i = 2'b01; threshold_i = 12'd299;
    send_frame(STEP, 1'b1, 0, 25, 1'b0, {8'd0, 8'd0, 8'd255}, 1'b1);
    mode_i = 2'b01; threshold_i = 12'd300;
    send_frame(STEP, 1'b1, 0, 25, 1'b0, {8'd255, 8'd255, 8'd255}, 1'b1);

    mode_i = 2'b00; threshold_i = 12'd50;
    fork
      send_frame(STEP, 1'b1, 0, 25, 1'b0, {8'd0, 8'd0, 8'd255}, 1'b1);
      begin
        repeat (8) @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        kwait = 0;
        do begin
          @(negedge clk_i);
          kwait++;
        end while (!out_valid_o && kwait < 50);
        check("stall_valid", 32'(out_valid_o), 32'(1));
        snap = {out_valid_o, out_data_o, out_sof_o, out_eol_o};
        for (int i = 0; i < 10; i++) begin
          @(negedge clk_i);
          check("stall_in_ready", 32'(in_ready_o), 32'(0));
          check("stall_hold", 32'({out_valid_o, out_data_o, out_sof_o, out_eol_o}), 32'(snap));
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join

    check("sof_err_clear", 32'(sof_err_o), 32'(0));
    mode_i = 2'b10; threshold_i = 12'd350;
    send_frame(STEP, 1'b1, 0, 7, 1'b0, 24'd0, 1'b0);
    send_frame(STEP, 1'b1, 0, 25, 1'b0, {8'd0, 8'd0, 8'd255}, 1'b1);
    check("sof_err_set", 32'(sof_err_o), 32'(1));

    mode_i = 2'b01; threshold_i = 12'd300;
    send_frame(STEP, 1'b1, 0, 13, 1'b0, 24'd0, 1'b0);
    #2;
    check("pre_reset_valid", 32'(out_valid_o), 32'(1));
    rst_ni = 1'b0;
    #1;
    check("async_reset_clear", 32'({out_valid_o, out_data_o, out_sof_o, out_eol_o, frame_done_o, sof_err_o}), 32'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_midframe_reset", 32'(in_ready_o), 32'(1));
    @(posedge clk_i);
    #1;
    send_frame(STEP, 1'b0, 0, 25, 1'b0, {8'd0, 8'd0, 8'd255}, 1'b1);

    kwait = 0;
    while (sb.size() != 0 && kwait < 100) begin
      @(posedge clk_i);
      kwait++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    check("frame_done_count", 32'(n_done), 32'(8));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
